pipe_stage_buf: RTL and testbench

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf_if.sv | 24 ++
 rtl/pipe_stage_buf.sv | 149 ++++++++++++++
 tb/tb_pipe_stage_buf.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pipe_stage_buf_if.sv
// Handshake bundle for pipe_stage_buf: upstream valid/ready/ctrl/data in, downstream valid/ready/ctrl/data out.
interface pipe_stage_buf_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [CTRL_WIDTH-1:0] in_ctrl;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with ctrl/payload and a saturating stall counter; PIPE_STAGE_SKID_EN adds a skid entry.
// Latency: one cycle from accepted input to out_valid; outputs come straight from the main register.
// Backpressure: skid build has registered in_ready (low only when both entries held); otherwise in_ready = !out_valid | out_ready.
module pipe_stage_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pipe_stage_buf_if.slave      bus,
    output logic [CNT_WIDTH-1:0] stall_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t                state;
    logic                  out_valid_q;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic [DATA_WIDTH-1:0] main_data;
    logic                  in_ready_w;
    logic                  xfer_in;
    logic                  xfer_out;

    assign bus.out_valid = out_valid_q;
    assign bus.out_ctrl  = main_ctrl;
    assign bus.out_data  = main_data;
    assign bus.in_ready  = in_ready_w;

    assign xfer_in  = bus.in_valid & in_ready_w;
    assign xfer_out = out_valid_q & bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic                  in_ready_q;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic [DATA_WIDTH-1:0] skid_data;

    assign in_ready_w = in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            main_ctrl   <= '0;
            main_data   <= '0;
            skid_ctrl   <= '0;
            skid_data   <= '0;
            in_ready_q  <= 1'b1;
        end else if (flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            main_ctrl   <= '0;
            skid_ctrl   <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        main_ctrl   <= bus.in_ctrl;
                        main_data   <= bus.in_data;
                        out_valid_q <= 1'b1;
                        state       <= FULL;
                    end
                end
                FULL: begin
                    if (xfer_in && xfer_out) begin
                        main_ctrl <= bus.in_ctrl;
                        main_data <= bus.in_data;
                    end else if (xfer_in) begin
                        // Downstream stalled: park the newcomer behind the main entry.
                        skid_ctrl  <= bus.in_ctrl;
                        skid_data  <= bus.in_data;
                        in_ready_q <= 1'b0;
                        state      <= SKID;
                    end else if (xfer_out) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                SKID: begin
                    if (xfer_out) begin
                        main_ctrl  <= skid_ctrl;
                        main_data  <= skid_data;
                        in_ready_q <= 1'b1;
                        state      <= FULL;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end
`else
    // A held entry can only be replaced in the cycle it leaves.
    assign in_ready_w = !out_valid_q | bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            main_ctrl   <= '0;
            main_data   <= '0;
        end else if (flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            main_ctrl   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        main_ctrl   <= bus.in_ctrl;
                        main_data   <= bus.in_data;
                        out_valid_q <= 1'b1;
                        state       <= FULL;
                    end
                end
                FULL: begin
                    if (xfer_in) begin
                        main_ctrl <= bus.in_ctrl;
                        main_data <= bus.in_data;
                    end else if (xfer_out) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!flush && out_valid_q && !bus.out_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed + random bench for pipe_stage_buf with a queue scoreboard; works for either skid build.
module tb_pipe_stage_buf;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int NW = 4;
    localparam int SAT = (1 << NW) - 1;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID_BUILD = 1'b1;
`else
    localparam bit SKID_BUILD = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [NW-1:0] stall_cnt;

    pipe_stage_buf_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) bus ();

    pipe_stage_buf #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [CW+DW-1:0] exp_q[$];
    int   stall_m   = 0;
    bit   ctrl_zero = 1'b1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs at negedge, then advance the model across the edge.
    task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                        input logic ordy, input logic fl);
        logic exp_rdy;
        logic [CW+DW-1:0] head;
        bus.in_valid  = v;
        bus.in_ctrl   = c;
        bus.in_data   = d;
        bus.out_ready = ordy;
        flush         = fl;
        @(negedge clk);
        exp_rdy = SKID_BUILD ? (exp_q.size() < 2) : (exp_q.size() == 0 || ordy);
        chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            chk("out_data", 64'(bus.out_data), 64'(head[DW-1:0]));
            chk("out_ctrl", 64'(bus.out_ctrl), 64'(head[CW+DW-1:DW]));
        end else if (ctrl_zero) begin
            chk("out_ctrl_zero", 64'(bus.out_ctrl), 64'd0);
        end
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        if (fl) begin
            exp_q.delete();
            ctrl_zero = 1'b1;
        end else begin
            if (exp_q.size() != 0 && !ordy && stall_m != SAT) stall_m++;
            if (exp_q.size() != 0 && ordy) void'(exp_q.pop_front());
            if (v && exp_rdy) begin
                exp_q.push_back({c, d});
                ctrl_zero = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_out_data"},  64'(bus.out_data),  64'd0);
        chk({tag, "_out_ctrl"},  64'(bus.out_ctrl),  64'd0);
        chk({tag, "_stall_cnt"}, 64'(stall_cnt),     64'd0);
        chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_ctrl   = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #3;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Streaming 1..8 with one-cycle latency and no stalls.
        for (int i = 1; i <= 8; i++) step(1'b1, CW'(i) | 4'h1, DW'(i), 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure: A, B, then C offered while downstream stalls; then drain.
        step(1'b1, 4'h3, 32'hAAAA_0001, 1'b0, 1'b0);
        step(1'b1, 4'h5, 32'hBBBB_0002, 1'b0, 1'b0);
        step(1'b1, 4'h7, 32'hCCCC_0003, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with a same-cycle input: nothing may come out afterwards.
        step(1'b1, 4'h9, 32'h0000_00A1, 1'b0, 1'b0);
        step(1'b1, 4'hB, 32'h0000_00B2, 1'b0, 1'b0);
        step(1'b1, 4'hD, 32'h0000_00C3, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, '0, 1'b1, 1'b0);

        // Saturation: a held entry stalled for 20 cycles.
        step(1'b1, 4'hE, 32'h5A5A_5A5A, 1'b0, 1'b0);
        repeat (20) step(1'b0, '0, '0, 1'b0, 1'b0);
        chk("stall_sat", 64'(stall_cnt), 64'(SAT));

        // Asynchronous reset between edges while holding an entry.
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async_rst");
        exp_q.delete();
        stall_m   = 0;
        ctrl_zero = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, 4'h6, 32'h1234_5678, 1'b1, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0);

        // Random valid/ready with occasional flush.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), CW'($urandom), DW'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
        end
        repeat (4) step(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
